// File: rtl/e_muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : e_muldiv_unit_if
// Brief    : EX-stage issue/result bundle between the pipeline and the mul/div unit.
// Revision : 1.0
// ============================================================================
interface e_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic [3:0]       op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             flush;
  logic             busy;
  logic [WIDTH-1:0] hilo_out;
  logic             div_zero;

  modport master (
    output op, rs, rt, flush,
    input  busy, hilo_out, div_zero
  );

  modport slave (
    input  op, rs, rt, flush,
    output busy, hilo_out, div_zero
  );
endinterface
`default_nettype wire

// File: rtl/e_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : e_muldiv_unit
// Brief    : Parametrised multiply/divide unit owning HI/LO, with MAC ops and flush.
// Revision : 1.0
// ============================================================================
module e_muldiv_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  wire logic       clk,
  input  wire logic       reset,
  e_muldiv_unit_if.slave  bus
);

  localparam logic [3:0] c_op_mult  = 4'd1;
  localparam logic [3:0] c_op_multu = 4'd2;
  localparam logic [3:0] c_op_div   = 4'd3;
  localparam logic [3:0] c_op_divu  = 4'd4;
  localparam logic [3:0] c_op_mthi  = 4'd5;
  localparam logic [3:0] c_op_mtlo  = 4'd6;
  localparam logic [3:0] c_op_mfhi  = 4'd7;
  localparam logic [3:0] c_op_mflo  = 4'd8;
  localparam logic [3:0] c_op_madd  = 4'd9;
  localparam logic [3:0] c_op_maddu = 4'd10;
  localparam logic [3:0] c_op_msub  = 4'd11;
  localparam logic [3:0] c_op_msubu = 4'd12;

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_run  = 1'b1;

  localparam int c_max_cycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int c_cw         = $clog2(c_max_cycles + 1);
  // The issue edge itself consumes one cycle of latency, so the counter loads N-1.
  localparam logic [c_cw-1:0] c_mult_load = c_cw'(MULT_CYCLES - 1);
  localparam logic [c_cw-1:0] c_div_load  = c_cw'(DIV_CYCLES - 1);
  localparam logic [c_cw-1:0] c_one       = c_cw'(1);

  logic [0:0]       state_q, state_d;
  logic [c_cw-1:0]  count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] tmp_hi_q, tmp_hi_d;
  logic [WIDTH-1:0] tmp_lo_q, tmp_lo_d;
  logic             dz_pend_q, dz_pend_d;
  logic             div_zero_q, div_zero_d;

  logic w_mul_signed, w_mul_unsigned, w_is_mul, w_is_div, w_start, w_busy_r;
  logic w_is_madd, w_is_msub;
  logic [c_cw-1:0] w_load;

  assign w_mul_signed   = (bus.op == c_op_mult)  || (bus.op == c_op_madd)  || (bus.op == c_op_msub);
  assign w_mul_unsigned = (bus.op == c_op_multu) || (bus.op == c_op_maddu) || (bus.op == c_op_msubu);
  assign w_is_mul       = w_mul_signed || w_mul_unsigned;
  assign w_is_div       = (bus.op == c_op_div) || (bus.op == c_op_divu);
  assign w_is_madd      = (bus.op == c_op_madd) || (bus.op == c_op_maddu);
  assign w_is_msub      = (bus.op == c_op_msub) || (bus.op == c_op_msubu);
  assign w_start        = (w_is_mul || w_is_div) && !bus.flush;
  assign w_busy_r       = (state_q == c_st_run);
  assign w_load         = w_is_div ? c_div_load : c_mult_load;

  // Multiply: one 2W-bit multiplier, operands sign- or zero-extended up front.
  logic [2*WIDTH-1:0] w_hilo, w_a_ext, w_b_ext, w_prod, w_mac;

  assign w_hilo  = {hi_q, lo_q};
  assign w_a_ext = w_mul_signed ? {{WIDTH{bus.rs[WIDTH-1]}}, bus.rs} : {{WIDTH{1'b0}}, bus.rs};
  assign w_b_ext = w_mul_signed ? {{WIDTH{bus.rt[WIDTH-1]}}, bus.rt} : {{WIDTH{1'b0}}, bus.rt};
  assign w_prod  = w_a_ext * w_b_ext;

  always_comb begin
    w_mac = w_prod;
    if (w_is_madd)      w_mac = w_hilo + w_prod;
    else if (w_is_msub) w_mac = w_hilo - w_prod;
  end

  // Divide on magnitudes, then restore signs; the overflow case falls out naturally.
  logic             w_div_signed, w_rs_neg, w_rt_neg, w_rt_zero;
  logic [WIDTH-1:0] w_dvd, w_dvs, w_dvs_safe, w_uq, w_ur, w_q, w_r;
  logic [2*WIDTH-1:0] w_div_res, w_result;

  assign w_div_signed = (bus.op == c_op_div);
  assign w_rs_neg     = w_div_signed && bus.rs[WIDTH-1];
  assign w_rt_neg     = w_div_signed && bus.rt[WIDTH-1];
  assign w_rt_zero    = (bus.rt == '0);
  assign w_dvd        = w_rs_neg ? (~bus.rs + 1'b1) : bus.rs;
  assign w_dvs        = w_rt_neg ? (~bus.rt + 1'b1) : bus.rt;
  assign w_dvs_safe   = w_rt_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : w_dvs;
  assign w_uq         = w_dvd / w_dvs_safe;
  assign w_ur         = w_dvd % w_dvs_safe;
  assign w_q          = (w_rs_neg ^ w_rt_neg) ? (~w_uq + 1'b1) : w_uq;
  assign w_r          = w_rs_neg ? (~w_ur + 1'b1) : w_ur;
  assign w_div_res    = w_rt_zero ? w_hilo : {w_r, w_q};
  assign w_result     = w_is_div ? w_div_res : w_mac;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    tmp_hi_d   = tmp_hi_q;
    tmp_lo_d   = tmp_lo_q;
    dz_pend_d  = dz_pend_q;
    div_zero_d = 1'b0;

    case (state_q)
      c_st_idle: begin
        if (w_start) begin
          tmp_hi_d  = w_result[2*WIDTH-1:WIDTH];
          tmp_lo_d  = w_result[WIDTH-1:0];
          dz_pend_d = w_is_div && w_rt_zero;
          // Single-cycle latency commits directly on the issue edge.
          if (w_load == '0) begin
            hi_d       = w_result[2*WIDTH-1:WIDTH];
            lo_d       = w_result[WIDTH-1:0];
            div_zero_d = w_is_div && w_rt_zero;
          end else begin
            state_d = c_st_run;
            count_d = w_load;
          end
        end else if (!bus.flush) begin
          if (bus.op == c_op_mthi) hi_d = bus.rs;
          if (bus.op == c_op_mtlo) lo_d = bus.rs;
        end
      end
      default: begin
        if (bus.flush) begin
          state_d = c_st_idle;
          count_d = '0;
        end else if (count_q == c_one) begin
          hi_d       = tmp_hi_q;
          lo_d       = tmp_lo_q;
          div_zero_d = dz_pend_q;
          state_d    = c_st_idle;
          count_d    = '0;
        end else begin
          count_d = count_q - c_one;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= c_st_idle;
      count_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      tmp_hi_q   <= '0;
      tmp_lo_q   <= '0;
      dz_pend_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      tmp_hi_q   <= tmp_hi_d;
      tmp_lo_q   <= tmp_lo_d;
      dz_pend_q  <= dz_pend_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.busy     = w_start || w_busy_r;
  assign bus.div_zero = div_zero_q;

  always_comb begin
    bus.hilo_out = '0;
    if (bus.op == c_op_mfhi)      bus.hilo_out = hi_q;
    else if (bus.op == c_op_mflo) bus.hilo_out = lo_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_e_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_e_muldiv_unit
// Brief    : Directed vector table plus hand sequences for e_muldiv_unit.
// Revision : 1.0
// ============================================================================
module tb_e_muldiv_unit;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  e_muldiv_unit_if #(.WIDTH(32)) bus ();
  e_muldiv_unit_if #(.WIDTH(16)) bus2 ();

  e_muldiv_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  e_muldiv_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] init_hi;
    logic [31:0] init_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_busy;
    logic        exp_dz;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(logic [3:0] op, logic [31:0] rs, logic [31:0] rt,
                              logic [31:0] ih, logic [31:0] il,
                              logic [31:0] eh, logic [31:0] el, int nb, logic dz);
    vec_t v;
    v.op = op; v.rs = rs; v.rt = rt; v.init_hi = ih; v.init_lo = il;
    v.exp_hi = eh; v.exp_lo = el; v.exp_busy = nb; v.exp_dz = dz;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_hilo(input logic [31:0] hi, input logic [31:0] lo);
    tick();
    bus.op = OP_MTHI; bus.rs = hi;
    tick();
    bus.op = OP_MTLO; bus.rs = lo;
    tick();
    bus.op = OP_NONE;
  endtask

  task automatic wait_idle(input string name);
    int cyc = 0;
    while (bus.busy && cyc < 50) begin
      tick();
      cyc++;
    end
    if (cyc >= 50) chk({name, "_timeout"}, 64'(cyc), 64'd0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cyc = 0;
    write_hilo(v.init_hi, v.init_lo);
    bus.op = v.op; bus.rs = v.rs; bus.rt = v.rt;
    #1;
    while (bus.busy && cyc < 50) begin
      cyc++;
      @(posedge clk);
      #1;
      bus.op = OP_NONE;
      #1;
    end
    chk($sformatf("v%0d_busy_cycles", idx), 64'(cyc), 64'(v.exp_busy));
    chk($sformatf("v%0d_div_zero", idx), 64'(bus.div_zero), 64'(v.exp_dz));
    @(posedge clk);
    #2;
    if (v.exp_dz) chk($sformatf("v%0d_div_zero_end", idx), 64'(bus.div_zero), 64'd0);
    bus.op = OP_MFHI;
    #1 chk($sformatf("v%0d_hi", idx), 64'(bus.hilo_out), 64'(v.exp_hi));
    bus.op = OP_MFLO;
    #1 chk($sformatf("v%0d_lo", idx), 64'(bus.hilo_out), 64'(v.exp_lo));
    bus.op = OP_NONE;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(OP_MULT,  32'hFFFFFFFD, 32'd7,        32'h0,    32'h0,    32'hFFFFFFFF, 32'hFFFFFFEB, 5,  1'b0);
    vecs[1]  = mk(OP_MADDU, 32'hFFFFFFFF, 32'd2,        32'h1,    32'h2,    32'h3,        32'h0,        5,  1'b0);
    vecs[2]  = mk(OP_DIV,   32'hFFFFFFF9, 32'd2,        32'h0,    32'h0,    32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1'b0);
    vecs[3]  = mk(OP_DIV,   32'h1234,     32'd0,        32'hAAAA, 32'h5555, 32'hAAAA,     32'h5555,     10, 1'b1);
    vecs[4]  = mk(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,    32'h0,    32'hFFFFFFFE, 32'h00000001, 5,  1'b0);
    vecs[5]  = mk(OP_DIVU,  32'hFFFFFFFF, 32'h10,       32'h0,    32'h0,    32'h0000000F, 32'h0FFFFFFF, 10, 1'b0);
    vecs[6]  = mk(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h5,    32'h6,    32'h0,        32'h80000000, 10, 1'b0);
    vecs[7]  = mk(OP_MSUB,  32'd2,        32'd3,        32'h0,    32'h0,    32'hFFFFFFFF, 32'hFFFFFFFA, 5,  1'b0);
    vecs[8]  = mk(OP_MADD,  32'hFFFFFFFF, 32'd5,        32'h0,    32'hA,    32'h0,        32'h5,        5,  1'b0);
    vecs[9]  = mk(OP_MSUBU, 32'hFFFFFFFF, 32'd1,        32'h1,    32'h0,    32'h0,        32'h1,        5,  1'b0);
    vecs[10] = mk(OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h0,    32'h0,    32'h1,        32'hFFFFFFFD, 10, 1'b0);
    vecs[11] = mk(OP_DIVU,  32'd5,        32'd0,        32'h12,   32'h34,   32'h12,       32'h34,       10, 1'b1);
    vecs[12] = mk(4'd13,    32'd5,        32'd5,        32'h7,    32'h8,    32'h7,        32'h8,        0,  1'b0);
    vecs[13] = mk(OP_MULT,  32'h80000000, 32'h80000000, 32'h0,    32'h0,    32'h40000000, 32'h0,        5,  1'b0);

    reset = 1'b1;
    bus.op = OP_NONE; bus.rs = '0; bus.rt = '0; bus.flush = 1'b0;
    bus2.op = OP_NONE; bus2.rs = '0; bus2.rt = '0; bus2.flush = 1'b0;
    #12 reset = 1'b0;
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_div_zero", 64'(bus.div_zero), 64'd0);
    bus.op = OP_MFHI;
    #1 chk("rst_hi", 64'(bus.hilo_out), 64'd0);
    bus.op = OP_MFLO;
    #1 chk("rst_lo", 64'(bus.hilo_out), 64'd0);
    bus.op = OP_NONE;

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // A second MULT while busy must be dropped.
    write_hilo(32'h0, 32'h0);
    bus.op = OP_MULT; bus.rs = 32'd3; bus.rt = 32'd4;
    tick();
    bus.op = OP_MULT; bus.rs = 32'd5; bus.rt = 32'd5;
    tick();
    bus.op = OP_NONE;
    repeat (4) tick();
    chk("ignore_busy", 64'(bus.busy), 64'd0);
    bus.op = OP_MFLO;
    #1 chk("ignore_lo", 64'(bus.hilo_out), 64'd12);
    bus.op = OP_MFHI;
    #1 chk("ignore_hi", 64'(bus.hilo_out), 64'd0);
    bus.op = OP_NONE;

    // Flush mid-run.
    tick();
    bus.op = OP_MULT; bus.rs = 32'd9; bus.rt = 32'd9;
    tick();
    bus.op = OP_NONE;
    tick();
    bus.flush = 1'b1;
    #1 chk("flush_busy_before", 64'(bus.busy), 64'd1);
    tick();
    bus.flush = 1'b0;
    #1 chk("flush_busy_after", 64'(bus.busy), 64'd0);
    repeat (6) tick();
    bus.op = OP_MFLO;
    #1 chk("flush_lo", 64'(bus.hilo_out), 64'd12);
    bus.op = OP_NONE;

    // Flush on the retire edge discards the result.
    tick();
    bus.op = OP_MULT; bus.rs = 32'd2; bus.rt = 32'd2;
    tick();
    bus.op = OP_NONE;
    repeat (3) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    #1 chk("flush_retire_busy", 64'(bus.busy), 64'd0);
    repeat (2) tick();
    bus.op = OP_MFLO;
    #1 chk("flush_retire_lo", 64'(bus.hilo_out), 64'd12);
    bus.op = OP_NONE;

    // Flush suppresses an issue from idle.
    tick();
    bus.flush = 1'b1; bus.op = OP_MULT; bus.rs = 32'd7; bus.rt = 32'd7;
    #1 chk("flush_issue_busy", 64'(bus.busy), 64'd0);
    tick();
    bus.flush = 1'b0; bus.op = OP_NONE;
    #1 chk("flush_issue_busy_next", 64'(bus.busy), 64'd0);
    repeat (6) tick();
    bus.op = OP_MFLO;
    #1 chk("flush_issue_lo", 64'(bus.hilo_out), 64'd12);
    bus.op = OP_NONE;

    // MTLO during a DIV is ignored; MFLO shows the old value while running.
    tick();
    bus.op = OP_DIV; bus.rs = 32'd100; bus.rt = 32'd7;
    tick();
    bus.op = OP_MTLO; bus.rs = 32'h99;
    tick();
    bus.op = OP_MFLO;
    #1 chk("run_old_lo", 64'(bus.hilo_out), 64'd12);
    wait_idle("div_run");
    #1 chk("div_run_lo", 64'(bus.hilo_out), 64'd14);
    bus.op = OP_MFHI;
    #1 chk("div_run_hi", 64'(bus.hilo_out), 64'd2);
    bus.op = OP_NONE;

    // Asynchronous reset in the middle of a DIV.
    tick();
    bus.op = OP_DIV; bus.rs = 32'd50; bus.rt = 32'd3;
    tick();
    bus.op = OP_MFLO;
    tick();
    tick();
    #2 reset = 1'b1;
    #1 chk("areset_busy", 64'(bus.busy), 64'd0);
    chk("areset_lo", 64'(bus.hilo_out), 64'd0);
    bus.op = OP_MFHI;
    #1 chk("areset_hi", 64'(bus.hilo_out), 64'd0);
    @(posedge clk);
    #3 reset = 1'b0;
    bus.op = OP_NONE;
    repeat (12) tick();
    bus.op = OP_MFLO;
    #1 chk("areset_no_writeback", 64'(bus.hilo_out), 64'd0);
    bus.op = OP_NONE;

    // 16-bit instance with single-cycle multiply.
    tick();
    bus2.op = OP_MULTU; bus2.rs = 16'hFFFF; bus2.rt = 16'hFFFF;
    #1 chk("w16_busy_issue", 64'(bus2.busy), 64'd1);
    tick();
    bus2.op = OP_NONE;
    #1 chk("w16_busy_after", 64'(bus2.busy), 64'd0);
    bus2.op = OP_MFHI;
    #1 chk("w16_hi", 64'(bus2.hilo_out), 64'hFFFE);
    bus2.op = OP_MFLO;
    #1 chk("w16_lo", 64'(bus2.hilo_out), 64'h0001);
    bus2.op = OP_NONE;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
